// File: rtl/membrane_q_readout_if.sv
// Q-value output channel of membrane_q_readout.
//   q_values : NUM_ACTIONS packed signed Q-values, q[a] at [a*Q_WIDTH +: Q_WIDTH]
//   q_valid  : q_values valid, held until accepted
//   q_ready  : consumer accepts q_values
// master = producer (readout), slave = consumer.
interface membrane_q_readout_if #(
    parameter int NUM_ACTIONS = 2,
    parameter int Q_WIDTH     = 24
);
    logic [NUM_ACTIONS*Q_WIDTH-1:0] q_values;
    logic                           q_valid;
    logic                           q_ready;

    modport master (output q_values, output q_valid, input  q_ready);
    modport slave  (input  q_values, input  q_valid, output q_ready);
endinterface

// File: rtl/membrane_q_readout.sv
// Reader end of the hidden-layer-2 membrane buffers. Once every buffer is full it
// sweeps all timesteps and neurons through the shared read port, accumulates the
// weighted membranes into one Q-value per action, presents the saturated Q-values
// on a valid/ready channel and finally pulses buffer_clear.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   buffers_full   full flag per buffer
//   read_timestep  timestep address shared by all buffers (combinational read)
//   membranes      buffer outputs, neuron n at [n*MW +: MW]
//   weights        w[a][n] at [(a*NN+n)*WW +: WW]
//   biases         bias[a] at [a*QW +: QW]
//   q_out          Q-value channel (q_values / q_valid / q_ready)
//   buffer_clear   one-cycle clear pulse to all buffers
//   busy           high whenever the FSM is not idle
module membrane_q_readout #(
    parameter int NUM_TIMESTEPS  = 30,
    parameter int NUM_NEURONS    = 16,
    parameter int NUM_ACTIONS    = 2,
    parameter int MEMBRANE_WIDTH = 24,
    parameter int WEIGHT_WIDTH   = 16,
    parameter int Q_WIDTH        = 24,
    parameter int SHIFT          = 8,
    localparam int TS_WIDTH      = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [NUM_NEURONS-1:0]                            buffers_full,
    output logic [TS_WIDTH-1:0]                               read_timestep,
    input  logic [NUM_NEURONS*MEMBRANE_WIDTH-1:0]             membranes,
    input  logic [NUM_ACTIONS*NUM_NEURONS*WEIGHT_WIDTH-1:0]   weights,
    input  logic [NUM_ACTIONS*Q_WIDTH-1:0]                    biases,
    membrane_q_readout_if.master                              q_out,
    output logic                                              buffer_clear,
    output logic                                              busy
);
    localparam int N_WIDTH    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int PROD_WIDTH = MEMBRANE_WIDTH + WEIGHT_WIDTH;
    localparam int ACC_WIDTH  = MEMBRANE_WIDTH + WEIGHT_WIDTH
                              + $clog2(NUM_TIMESTEPS*NUM_NEURONS) + 1;

    // Saturation bounds expressed at the ACC_WIDTH+1 bit add width.
    localparam logic signed [ACC_WIDTH:0] Q_MAX =
        {{(ACC_WIDTH-Q_WIDTH+2){1'b0}}, {(Q_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] Q_MIN =
        {{(ACC_WIDTH-Q_WIDTH+2){1'b1}}, {(Q_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACCUM, FINAL, OUTPUT, CLEAR} state_t;

    state_t                       state, state_next;
    logic [TS_WIDTH-1:0]          t_cnt;
    logic [N_WIDTH-1:0]           n_cnt;
    int unsigned                  n_idx;
    logic                         all_full;
    logic                         last_step;
    logic signed [MEMBRANE_WIDTH-1:0] mem_sel;
    logic signed [WEIGHT_WIDTH-1:0]   w_sel  [NUM_ACTIONS];
    logic signed [PROD_WIDTH-1:0]     prod   [NUM_ACTIONS];
    logic signed [ACC_WIDTH-1:0]      acc    [NUM_ACTIONS];
    logic signed [ACC_WIDTH-1:0]      acc_shr[NUM_ACTIONS];
    logic signed [ACC_WIDTH:0]        q_sum  [NUM_ACTIONS];
    logic signed [Q_WIDTH-1:0]        q_sat  [NUM_ACTIONS];

    assign all_full      = &buffers_full;
    assign last_step     = (t_cnt == TS_WIDTH'(NUM_TIMESTEPS-1)) &&
                           (n_cnt == N_WIDTH'(NUM_NEURONS-1));
    assign n_idx         = 32'(n_cnt);
    assign read_timestep = t_cnt;

    // Control outputs are pure decodes of the state register.
    assign busy          = (state != IDLE);
    assign q_out.q_valid = (state == OUTPUT);
    assign buffer_clear  = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (all_full) state_next = ACCUM;
            ACCUM:   if (last_step) state_next = FINAL;
            FINAL:   state_next = OUTPUT;
            OUTPUT:  if (q_out.q_ready) state_next = CLEAR;
            CLEAR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-action product of the current neuron, and the saturated result
    // of the shifted accumulator plus bias.
    always_comb begin
        mem_sel = membranes[n_idx*MEMBRANE_WIDTH +: MEMBRANE_WIDTH];
        for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
            w_sel[a]   = weights[(a*NUM_NEURONS + n_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            prod[a]    = mem_sel * w_sel[a];
            acc_shr[a] = acc[a] >>> SHIFT;
            q_sum[a]   = {acc_shr[a][ACC_WIDTH-1], acc_shr[a]}
                       + {{(ACC_WIDTH+1-Q_WIDTH){biases[a*Q_WIDTH + Q_WIDTH-1]}},
                          biases[a*Q_WIDTH +: Q_WIDTH]};
            if (q_sum[a] > Q_MAX)
                q_sat[a] = {1'b0, {(Q_WIDTH-1){1'b1}}};
            else if (q_sum[a] < Q_MIN)
                q_sat[a] = {1'b1, {(Q_WIDTH-1){1'b0}}};
            else
                q_sat[a] = q_sum[a][Q_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_cnt          <= '0;
            n_cnt          <= '0;
            q_out.q_values <= '0;
            for (int unsigned a = 0; a < NUM_ACTIONS; a++) acc[a] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (all_full) begin
                        t_cnt <= '0;
                        n_cnt <= '0;
                        for (int unsigned a = 0; a < NUM_ACTIONS; a++) acc[a] <= '0;
                    end
                end
                ACCUM: begin
                    for (int unsigned a = 0; a < NUM_ACTIONS; a++)
                        acc[a] <= acc[a]
                                + {{(ACC_WIDTH-PROD_WIDTH){prod[a][PROD_WIDTH-1]}}, prod[a]};
                    if (n_cnt == N_WIDTH'(NUM_NEURONS-1)) begin
                        n_cnt <= '0;
                        t_cnt <= t_cnt + TS_WIDTH'(1);
                    end else begin
                        n_cnt <= n_cnt + N_WIDTH'(1);
                    end
                end
                FINAL: begin
                    for (int unsigned a = 0; a < NUM_ACTIONS; a++)
                        q_out.q_values[a*Q_WIDTH +: Q_WIDTH] <= q_sat[a];
                end
                CLEAR:   t_cnt <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_membrane_q_readout.sv
// Self-checking bench for membrane_q_readout. Emulates the buffers' combinational
// read port from a membrane table and compares against a behavioural Q-value model.
module tb_membrane_q_readout;
    localparam int NT = 30, NN = 16, NA = 2, MW = 24, WW = 16, QW = 24, SHIFT = 8, TW = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NN-1:0]       buffers_full;
    logic [TW-1:0]       read_timestep;
    logic [NN*MW-1:0]    membranes;
    logic [NA*NN*WW-1:0] weights;
    logic [NA*QW-1:0]    biases;
    logic                buffer_clear;
    logic                busy;

    membrane_q_readout_if #(.NUM_ACTIONS(NA), .Q_WIDTH(QW)) q_bus ();

    membrane_q_readout #(
        .NUM_TIMESTEPS(NT), .NUM_NEURONS(NN), .NUM_ACTIONS(NA),
        .MEMBRANE_WIDTH(MW), .WEIGHT_WIDTH(WW), .Q_WIDTH(QW), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .buffers_full(buffers_full),
        .read_timestep(read_timestep), .membranes(membranes), .weights(weights),
        .biases(biases), .q_out(q_bus), .buffer_clear(buffer_clear), .busy(busy)
    );

    always #5 clk = ~clk;

    int mem  [NN][NT];
    int w    [NA][NN];
    int bias [NA];

    always_comb begin
        membranes = '0;
        for (int n = 0; n < NN; n++)
            if (int'(read_timestep) < NT)
                membranes[n*MW +: MW] = MW'(mem[n][read_timestep]);
    end

    always_comb begin
        weights = '0;
        biases  = '0;
        for (int a = 0; a < NA; a++) begin
            biases[a*QW +: QW] = QW'(bias[a]);
            for (int n = 0; n < NN; n++)
                weights[(a*NN+n)*WW +: WW] = WW'(w[a][n]);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_q(int a);
        longint acc, qmax, qmin;
        acc = 0;
        for (int t = 0; t < NT; t++)
            for (int n = 0; n < NN; n++)
                acc += longint'(mem[n][t]) * longint'(w[a][n]);
        acc  = (acc >>> SHIFT) + longint'(bias[a]);
        qmax = (longint'(1) <<< (QW-1)) - 1;
        qmin = -(longint'(1) <<< (QW-1));
        if (acc > qmax) return qmax;
        if (acc < qmin) return qmin;
        return acc;
    endfunction

    function automatic longint dut_q(int a);
        logic signed [QW-1:0] v;
        v = q_bus.q_values[a*QW +: QW];
        return longint'(v);
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"},  longint'(busy), 0);
        check_eq({tag, "_rdts"},  longint'(read_timestep), 0);
        check_eq({tag, "_valid"}, longint'(q_bus.q_valid), 0);
        check_eq({tag, "_clear"}, longint'(buffer_clear), 0);
    endtask

    task automatic run_inference(input string tag, input bit check_addr, input int hold_cycles);
        longint expq [NA];
        int     cyc;
        bit     got;
        for (int a = 0; a < NA; a++) expq[a] = model_q(a);
        @(negedge clk);
        buffers_full = '1;
        q_bus.q_ready = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) buffers_full = {1'b0, 15'($urandom)};
            if (q_bus.q_valid) got = 1'b1;
            else if (check_addr && cyc <= NT*NN)
                check_eq({tag, "_addr"}, longint'(read_timestep), longint'((cyc-1)/NN));
        end
        check_eq({tag, "_latency"}, longint'(cyc), longint'(NT*NN+2));
        for (int a = 0; a < NA; a++) check_eq($sformatf("%s_q%0d", tag, a), dut_q(a), expq[a]);
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, longint'(q_bus.q_valid), 1);
            check_eq({tag, "_hold_clear"}, longint'(buffer_clear), 0);
            for (int a = 0; a < NA; a++) check_eq({tag, "_hold_q"}, dut_q(a), expq[a]);
        end
        q_bus.q_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_hs_clear"}, longint'(buffer_clear), 1);
        check_eq({tag, "_hs_valid"}, longint'(q_bus.q_valid), 0);
        check_eq({tag, "_hs_busy"},  longint'(busy), 1);
        q_bus.q_ready = 1'b0;
        @(negedge clk);
        check_quiet({tag, "_idle"});
        for (int a = 0; a < NA; a++) check_eq({tag, "_kept_q"}, dut_q(a), expq[a]);
    endtask

    task automatic fill_const(input int m, input int w0, input int w1, input int b0, input int b1);
        for (int n = 0; n < NN; n++) begin
            for (int t = 0; t < NT; t++) mem[n][t] = m;
            w[0][n] = w0;
            w[1][n] = w1;
        end
        bias[0] = b0;
        bias[1] = b1;
    endtask

    task automatic fill_random();
        logic signed [23:0] r24;
        logic signed [15:0] r16;
        int ms, ws;
        ms = int'($urandom_range(0, 16));
        ws = int'($urandom_range(0, 8));
        for (int n = 0; n < NN; n++) begin
            for (int t = 0; t < NT; t++) begin
                r24 = 24'($urandom);
                mem[n][t] = int'(r24) >>> ms;
            end
            for (int a = 0; a < NA; a++) begin
                r16 = 16'($urandom);
                w[a][n] = int'(r16) >>> ws;
            end
        end
        for (int a = 0; a < NA; a++) begin
            r24 = 24'($urandom);
            bias[a] = int'(r24) >>> int'($urandom_range(0, 23));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        buffers_full = '0;
        q_bus.q_ready = 1'b0;
        fill_const(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check_eq("reset_q0", dut_q(0), 0);
        check_eq("reset_q1", dut_q(1), 0);
        reset = 1'b0;

        // Partial full with a stray ready must leave the block idle.
        buffers_full = 16'h7FFF;
        q_bus.q_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i % 25 == 0) check_quiet("partial");
        end
        q_bus.q_ready = 1'b0;
        buffers_full = '0;

        fill_const(256, 1, -1, 0, 0);
        run_inference("t1", 1'b1, 0);
        check_eq("t1_q0_const", dut_q(0), 480);
        check_eq("t1_q1_const", dut_q(1), -480);

        fill_random();
        for (int n = 0; n < NN; n++) begin
            for (int t = 0; t < NT; t++) mem[n][t] = t*16 + n;
            w[0][n] = 1;
        end
        bias[0] = 0;
        run_inference("t3", 1'b1, 0);
        check_eq("t3_q0_const", dut_q(0), 449);

        fill_random();
        run_inference("t4", 1'b0, 10);

        fill_const(8388607, 32767, 32767, 8388607, 0);
        run_inference("t5pos", 1'b0, 0);
        check_eq("t5_q0_max", dut_q(0), 8388607);
        fill_const(8388607, -32767, -32767, 8388607, 0);
        run_inference("t5neg", 1'b0, 0);
        check_eq("t5_q0_min", dut_q(0), -8388608);

        // Abort mid-accumulation, then rerun cleanly.
        fill_const(256, 1, -1, 0, 0);
        @(negedge clk);
        buffers_full = '1;
        repeat (100) @(negedge clk);
        buffers_full = '0;
        reset = 1'b1;
        @(negedge clk);
        check_quiet("t6_reset");
        check_eq("t6_reset_q0", dut_q(0), 0);
        check_eq("t6_reset_q1", dut_q(1), 0);
        reset = 1'b0;
        run_inference("t6", 1'b0, 0);
        check_eq("t6_q0_const", dut_q(0), 480);
        check_eq("t6_q1_const", dut_q(1), -480);

        for (int i = 0; i < 4; i++) begin
            fill_random();
            run_inference($sformatf("rnd%0d", i), i == 0, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
